// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: fetch PC, 1-cycle SRAM interface, one-entry stall hold buffer.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        im_ce_o,
  output logic [31:0] im_addr_o,
  input  logic [31:0] im_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
);

  logic        run_q;
  logic [31:0] pc_q,        pc_d;
  logic        rsp_vld_q,   rsp_vld_d;
  logic [31:0] rsp_pc_q,    rsp_pc_d;
  logic        hold_vld_q,  hold_vld_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc_q,   hold_pc_d;

  logic        issue;
  logic        accept;
  logic        unused_tgt_lsb;

  // Targets are word aligned; the low bits of the redirect address are dropped.
  assign unused_tgt_lsb = ^branch_target_i[1:0];

  assign issue     = run_q & (flush_i | ~stall_i);
  assign im_ce_o   = issue;
  assign im_addr_o = flush_i ? {branch_target_i[31:2], 2'b00} : pc_q;

  always_comb begin
    inst_o  = NOP_INST;
    pc_o    = rsp_pc_q;
    valid_o = 1'b0;
    if (hold_vld_q) begin
      inst_o  = hold_inst_q;
      pc_o    = hold_pc_q;
      valid_o = 1'b1;
    end else if (rsp_vld_q) begin
      inst_o  = im_rdata_i;
      valid_o = 1'b1;
    end
    // A redirect kills whatever is on the output this cycle.
    if (flush_i) begin
      inst_o  = NOP_INST;
      valid_o = 1'b0;
    end
  end

  assign accept = valid_o & ~stall_i & ~flush_i;

  always_comb begin
    pc_d        = pc_q;
    rsp_vld_d   = 1'b0;
    rsp_pc_d    = rsp_pc_q;
    hold_vld_d  = hold_vld_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;

    if (issue) begin
      pc_d      = im_addr_o + 32'd4;
      rsp_vld_d = 1'b1;
      rsp_pc_d  = im_addr_o;
    end

    if (flush_i) begin
      hold_vld_d = 1'b0;
    end else if (stall_i) begin
      if (rsp_vld_q && !hold_vld_q) begin
        hold_vld_d  = 1'b1;
        hold_inst_d = im_rdata_i;
        hold_pc_d   = rsp_pc_q;
      end
    end else begin
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q       <= 1'b0;
      pc_q        <= RESET_PC;
      rsp_vld_q   <= 1'b0;
      rsp_pc_q    <= RESET_PC;
      hold_vld_q  <= 1'b0;
      hold_inst_q <= NOP_INST;
      hold_pc_q   <= RESET_PC;
    end else begin
      run_q       <= 1'b1;
      pc_q        <= pc_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_pc_q    <= rsp_pc_d;
      hold_vld_q  <= hold_vld_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      if (accept) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (run_q && !valid_o) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign fetch_cnt_o   = 32'h0;
  assign bubble_cnt_o  = 32'h0;
`endif

`ifndef SYNTHESIS
  hold_rsp_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(hold_vld_q && rsp_vld_q));
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: vector table plus reset and PC-wrap sequences.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        ce, ce2;
  logic [31:0] addr, addr2, rdata, rdata2;
  logic [31:0] pc, pc2, inst, inst2, fcnt, fcnt2, bcnt, bcnt2;
  logic        valid, valid2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA000_0000 ^ a;
  endfunction

  // SRAM: one-cycle latency; garbage when not requested so stale data shows up.
  always @(posedge clk) rdata  <= ce  ? word_at(addr)  : 32'hDEAD_BEEF;
  always @(posedge clk) rdata2 <= ce2 ? word_at(addr2) : 32'hDEAD_BEEF;

  if_fetch_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .flush_i(flush),
    .branch_target_i(tgt), .im_ce_o(ce), .im_addr_o(addr), .im_rdata_i(rdata),
    .pc_o(pc), .inst_o(inst), .valid_o(valid), .fetch_cnt_o(fcnt), .bubble_cnt_o(bcnt)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk_i(clk), .rst_ni(rst2_n), .stall_i(1'b0), .flush_i(1'b0),
    .branch_target_i(32'h0), .im_ce_o(ce2), .im_addr_o(addr2), .im_rdata_i(rdata2),
    .pc_o(pc2), .inst_o(inst2), .valid_o(valid2), .fetch_cnt_o(fcnt2), .bubble_cnt_o(bcnt2)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] tgt;
    logic        ce;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[15];
  logic [31:0] exp_f, exp_b;

  initial begin
    //          stall flush target        ce    addr          valid pc            inst
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   NOP};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   NOP};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   32'hA000_0000};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,   32'hA000_0004};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h8,   32'hA000_0008};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h8,   32'hA000_0008};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h8,   32'hA000_0008};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8,   32'hA000_0008};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC,   32'hA000_000C};
    vecs[9]  = '{1'b0, 1'b1, 32'h103, 1'b1, 32'h100, 1'b0, 32'h10,  NOP};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100, 32'hA000_0100};
    vecs[11] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h108, 1'b1, 32'h104, 32'hA000_0104};
    vecs[12] = '{1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h104, NOP};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200, 32'hA000_0200};
    vecs[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h204, 32'hA000_0204};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst ce", {31'h0, ce}, 32'h0);
    check("rst valid", {31'h0, valid}, 32'h0);
    check("rst inst", inst, NOP);
    check("rst pc", pc, 32'h0);
    check("rst fcnt", fcnt, 32'h0);
    check("rst bcnt", bcnt, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    exp_f = 32'h0;
    exp_b = 32'h0;
    for (int i = 0; i < 15; i++) begin
      stall = vecs[i].stall;
      flush = vecs[i].flush;
      tgt   = vecs[i].tgt;
      #1;
      check($sformatf("v%0d ce", i), {31'h0, ce}, {31'h0, vecs[i].ce});
      check($sformatf("v%0d addr", i), addr, vecs[i].addr);
      check($sformatf("v%0d valid", i), {31'h0, valid}, {31'h0, vecs[i].valid});
      check($sformatf("v%0d pc", i), pc, vecs[i].pc);
      check($sformatf("v%0d inst", i), inst, vecs[i].inst);
`ifdef IF_PERF_CNT_EN
      check($sformatf("v%0d fcnt", i), fcnt, exp_f);
      check($sformatf("v%0d bcnt", i), bcnt, exp_b);
`else
      check($sformatf("v%0d fcnt", i), fcnt, 32'h0);
      check($sformatf("v%0d bcnt", i), bcnt, 32'h0);
`endif
      if (vecs[i].valid && !vecs[i].stall && !vecs[i].flush) exp_f = exp_f + 32'd1;
      if (i > 0 && !vecs[i].valid) exp_b = exp_b + 32'd1;
      @(negedge clk);
    end

    // Reset pulsed mid-stall: capture then hold, then async reset.
    stall = 1'b1;
    flush = 1'b0;
    tgt   = 32'h0;
    @(negedge clk);
    #2;
    check("mid hold valid", {31'h0, valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid rst valid", {31'h0, valid}, 32'h0);
    check("mid rst ce", {31'h0, ce}, 32'h0);
    check("mid rst pc", pc, 32'h0);
    check("mid rst inst", inst, NOP);
    check("mid rst fcnt", fcnt, 32'h0);
    check("mid rst bcnt", bcnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    #1;
    check("re c0 ce", {31'h0, ce}, 32'h0);
    @(negedge clk);
    #1;
    check("re c1 ce", {31'h0, ce}, 32'h1);
    check("re c1 addr", addr, 32'h0);
    check("re c1 valid", {31'h0, valid}, 32'h0);
    @(negedge clk);
    #1;
    check("re c2 valid", {31'h0, valid}, 32'h1);
    check("re c2 pc", pc, 32'h0);
    check("re c2 inst", inst, 32'hA000_0000);

    // PC wrap at the top of the address space.
    rst2_n = 1'b1;
    @(negedge clk);
    #1;
    check("wrap c1 addr", addr2, 32'hFFFF_FFF8);
    @(negedge clk);
    #1;
    check("wrap c2 valid", {31'h0, valid2}, 32'h1);
    check("wrap c2 pc", pc2, 32'hFFFF_FFF8);
    check("wrap c2 inst", inst2, 32'h5FFF_FFF8);
    check("wrap c2 addr", addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    check("wrap c3 pc", pc2, 32'hFFFF_FFFC);
    check("wrap c3 addr", addr2, 32'h0);
    @(negedge clk);
    #1;
    check("wrap c4 pc", pc2, 32'h0);
    check("wrap c4 inst", inst2, 32'hA000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
